bytecode_fetch: RTL and testbench
=================================

# bytecode_fetch

Instruction fetch stage directly upstream of `control`. Reads Java bytecode bytes from a synchronous-read program memory, assembles each instruction (opcode plus 0–2 operand bytes) and presents it to `control` through a valid/ready handshake. Also accepts branch redirects from `control`.

## Interface
- `PC_WIDTH`, default 16: program counter and memory address width.
- `RESET_PC`, default 0: first fetch address after reset.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_addr` out PC_WIDTH: program memory byte address.
- `mem_rd` out 1: read strobe; data returns on `mem_data` the following cycle.
- `mem_data` in 8: read data, valid the cycle after `mem_rd`.
- `op_code` out 8: opcode of the presented instruction.
- `operand` out 16: raw operand bytes, zero-extended, first byte most significant.
- `operand_len` out 2: operand byte count (0, 1, 2).
- `instr_pc` out PC_WIDTH: address of the opcode byte.
- `instr_valid` out 1: instruction outputs valid.
- `instr_ready` in 1: `control` accepts the instruction.
- `branch_en` in 1: one-cycle redirect request.
- `branch_target` in PC_WIDTH: redirect address.

## Operation
- State register `pc`: next byte address to issue. Wraps modulo 2^PC_WIDTH.
- States:
  - F_OP: issue `pc`, `pc`++, go to L_OP.
  - L_OP: latch `op_code`, `instr_pc`. Decode the length from `mem_data` combinationally.
    - len>0: issue `pc`, `pc`++, go to L_ARG1.
    - Otherwise go to PRESENT.
  - L_ARG1: latch the first byte.
    - len=2: issue `pc`, `pc`++, go to L_ARG2.
    - Otherwise `operand`={8'h00, byte}, go to PRESENT.
  - L_ARG2: `operand`={first, byte}, go to PRESENT.
  - PRESENT: `instr_valid`=1.
    - On `instr_ready`: issue `pc`, `pc`++, go to L_OP. This is a fused fetch with no F_OP bubble.
    - Otherwise hold.
- Length table:
  - 1 byte: 0x10, 0x12, 0x15–0x19, 0x36–0x3A, 0xA9, 0xBC.
  - 2 bytes: 0x11, 0x84, 0x99–0xA8, 0xB2–0xB8, 0xBB, 0xBD.
  - All others: 0. This includes 0xAA and 0xAB, which are unsupported here.
- `mem_rd`=1 exactly in the cycles that issue an address. Otherwise `mem_rd`=0, and `mem_addr` holds its last value.
- Branch: `branch_en`=1 in any state has these effects:
  - `pc`<=`branch_target`.
  - Next state is F_OP.
  - `instr_valid`<=0.
  - Any byte returning next cycle is discarded.
  - Branch beats `instr_ready`.
- If `instr_valid`, `instr_ready` and `branch_en` are all 1 in the same cycle, the instruction counts as accepted and the fetch is redirected.
- Reset values:
  - `pc`=RESET_PC, state F_OP.
  - `op_code`=0x00, `operand`=0, `operand_len`=0, `instr_pc`=0.
  - `instr_valid`=0, `mem_rd`=0, `mem_addr`=0.
- Reset asserted mid-instruction aborts the instruction immediately. The partial instruction is never presented.

## Timing
- After `rst_n` rises: first F_OP issue at the next edge. A 0-operand instruction is valid 2 cycles after F_OP; 1-operand after 3; 2-operand after 4.
- With `instr_ready` tied high, each instruction takes a steady-state 2 + len cycles of PRESENT and fetch.
- With `instr_ready` low, `op_code`/`operand`/`operand_len`/`instr_pc` stay stable while `instr_valid`=1, and no memory reads are issued.
- Branch latency: `branch_en` in cycle N, `mem_addr`=`branch_target` with `mem_rd`=1 in cycle N+1, first redirected instruction valid no earlier than N+3.
- Outputs are registered. `mem_addr`/`mem_rd` are combinational from state and `pc`.

## Test plan
- Memory 02 03 04 60, `instr_ready`=1 → opcodes 0x02, 0x03, 0x04, 0x60 with `instr_pc` 0, 1, 2, 3, `operand_len` 0, one every 2 cycles.
- Memory 10 FF 11 12 34 → first instruction `op_code`=0x10, `operand`=0x00FF, len 1, pc 0. Second instruction `op_code`=0x11, `operand`=0x1234, len 2, pc 2.
- Hold `instr_ready`=0 for 5 cycles on the 0x11 instruction → outputs stable, `mem_rd`=0 throughout. Raise `instr_ready` → next read at address 5.
- `branch_en`=1 with `branch_target`=0x0040 during L_ARG1 of an `A7 xx xx` → partial instruction dropped, next read at 0x0040, next presented `instr_pc`=0x0040.
- With `PC_WIDTH`=4 and `RESET_PC`=15, memory[15]=0x10, memory[0]=0x7F → `operand`=0x007F, then the next fetch is from address 1.
- Assert `rst_n` low during L_ARG2 → all outputs return to reset values asynchronously. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/bytecode_fetch.sv
// Bytecode fetch stage: reads opcode and operand bytes from a synchronous-read
// program memory and presents whole instructions to control via valid/ready.
module bytecode_fetch #(
  parameter int PC_WIDTH = 16,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_data,
  output logic [7:0]          op_code,
  output logic [15:0]         operand,
  output logic [1:0]          operand_len,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target
);

  typedef enum logic [2:0] {
    F_OP    = 3'd0,
    L_OP    = 3'd1,
    L_ARG1  = 3'd2,
    L_ARG2  = 3'd3,
    PRESENT = 3'd4
  } state_t;

  // Operand byte count per opcode; unsupported or unlisted opcodes are 0.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd0;
    if (op == 8'h10 || op == 8'h12 ||
        (op >= 8'h15 && op <= 8'h19) ||
        (op >= 8'h36 && op <= 8'h3A) ||
        op == 8'hA9 || op == 8'hBC) begin
      len = 2'd1;
    end else if (op == 8'h11 || op == 8'h84 ||
                 (op >= 8'h99 && op <= 8'hA8) ||
                 (op >= 8'hB2 && op <= 8'hB8) ||
                 op == 8'hBB || op == 8'hBD) begin
      len = 2'd2;
    end else begin
      len = 2'd0;
    end
    return len;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] last_addr_r;
  logic                issue_s;
  logic [1:0]          mem_len_s;

  assign mem_len_s = op_len(mem_data);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= F_OP;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and read-issue decision; a redirect overrides everything
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    if (branch_en) begin
      state_nxt_s = F_OP;
      issue_s     = 1'b0;
    end else begin
      case (state_r)
        F_OP: begin
          issue_s     = 1'b1;
          state_nxt_s = L_OP;
        end
        L_OP: begin
          if (mem_len_s != 2'd0) begin
            issue_s     = 1'b1;
            state_nxt_s = L_ARG1;
          end else begin
            issue_s     = 1'b0;
            state_nxt_s = PRESENT;
          end
        end
        L_ARG1: begin
          if (operand_len == 2'd2) begin
            issue_s     = 1'b1;
            state_nxt_s = L_ARG2;
          end else begin
            issue_s     = 1'b0;
            state_nxt_s = PRESENT;
          end
        end
        L_ARG2: begin
          issue_s     = 1'b0;
          state_nxt_s = PRESENT;
        end
        PRESENT: begin
          // Accepting the instruction fetches the next opcode in the same cycle
          if (instr_ready) begin
            issue_s     = 1'b1;
            state_nxt_s = L_OP;
          end else begin
            issue_s     = 1'b0;
            state_nxt_s = PRESENT;
          end
        end
        default: begin
          issue_s     = 1'b0;
          state_nxt_s = F_OP;
        end
      endcase
    end
  end

  // Memory port: rst_n gating keeps the strobe low while reset is held
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = last_addr_r;
    if (issue_s && rst_n) begin
      mem_rd   = 1'b1;
      mem_addr = pc_r;
    end else begin
      mem_rd   = 1'b0;
      mem_addr = last_addr_r;
    end
  end

  // Program counter, instruction fields and valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r        <= PC_WIDTH'(RESET_PC);
      last_addr_r <= {PC_WIDTH{1'b0}};
      op_code     <= 8'h00;
      operand     <= 16'h0000;
      operand_len <= 2'd0;
      instr_pc    <= {PC_WIDTH{1'b0}};
      instr_valid <= 1'b0;
    end else begin
      if (branch_en) begin
        pc_r <= branch_target;
      end else if (issue_s) begin
        pc_r        <= pc_r + PC_WIDTH'(1);
        last_addr_r <= pc_r;
      end else begin
        pc_r <= pc_r;
      end
      instr_valid <= (state_nxt_s == PRESENT);
      if (!branch_en) begin
        case (state_r)
          L_OP: begin
            // last_addr_r still holds the opcode address: nothing issued since
            op_code     <= mem_data;
            instr_pc    <= last_addr_r;
            operand_len <= mem_len_s;
            operand     <= 16'h0000;
          end
          L_ARG1: begin
            operand <= {8'h00, mem_data};
          end
          L_ARG2: begin
            operand <= {operand[7:0], mem_data};
          end
          default: begin
            operand <= operand;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bytecode_fetch.sv
// Bench for bytecode_fetch: directed scenarios plus random ready/branch traffic
// checked against an instruction-level model of the program in memory.
module tb_bytecode_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        rst_n;
  logic [15:0] mem_addr_a;
  logic        mem_rd_a;
  logic [7:0]  mem_data_a;
  logic [7:0]  op_code_a;
  logic [15:0] operand_a;
  logic [1:0]  operand_len_a;
  logic [15:0] instr_pc_a;
  logic        instr_valid_a;
  logic        ready_a;
  logic        branch_en_a;
  logic [15:0] branch_target_a;
  logic [7:0]  mem_a [0:65535];

  // Instance B: 4-bit PC starting at 15
  logic        rst_nb;
  logic [3:0]  mem_addr_b;
  logic        mem_rd_b;
  logic [7:0]  mem_data_b;
  logic [7:0]  op_code_b;
  logic [15:0] operand_b;
  logic [1:0]  operand_len_b;
  logic [3:0]  instr_pc_b;
  logic        instr_valid_b;
  logic        ready_b;
  logic        branch_en_b;
  logic [3:0]  branch_target_b;
  logic [7:0]  mem_b [0:15];

  bytecode_fetch dut_a (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
    .mem_data(mem_data_a), .op_code(op_code_a), .operand(operand_a),
    .operand_len(operand_len_a), .instr_pc(instr_pc_a), .instr_valid(instr_valid_a),
    .instr_ready(ready_a), .branch_en(branch_en_a), .branch_target(branch_target_a)
  );

  bytecode_fetch #(.PC_WIDTH(4), .RESET_PC(15)) dut_b (
    .clk(clk), .rst_n(rst_nb), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
    .mem_data(mem_data_b), .op_code(op_code_b), .operand(operand_b),
    .operand_len(operand_len_b), .instr_pc(instr_pc_b), .instr_valid(instr_valid_b),
    .instr_ready(ready_b), .branch_en(branch_en_b), .branch_target(branch_target_b)
  );

  always @(posedge clk) begin
    if (mem_rd_a) mem_data_a <= mem_a[mem_addr_a];
    if (mem_rd_b) mem_data_b <= mem_b[mem_addr_b];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_len(input logic [7:0] op);
    if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC}) return 1;
    if (op inside {8'h11, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8], 8'hBB, 8'hBD}) return 2;
    return 0;
  endfunction

  // Instruction-level model state
  logic [15:0] model_pc;
  int          cyc;
  int          exp_valid_at;
  logic [15:0] last_rd_addr;
  logic        prev_hold;
  logic        prev_br;
  logic [15:0] prev_tgt;
  logic [7:0]  prev_op;
  logic [15:0] prev_operand;
  logic [1:0]  prev_len;
  logic [15:0] prev_pc;

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem_a[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ready_a = 1'b0;
    branch_en_a = 1'b0;
    #1;
    chk("rst_op", op_code_a, 8'h00);
    chk("rst_operand", operand_a, 16'h0000);
    chk("rst_len", operand_len_a, 2'd0);
    chk("rst_ipc", instr_pc_a, 16'h0000);
    chk("rst_valid", instr_valid_a, 1'b0);
    chk("rst_rd", mem_rd_a, 1'b0);
    chk("rst_addr", mem_addr_a, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_pc     = 16'h0000;
    cyc          = 0;
    exp_valid_at = 2 + ref_len(mem_a[16'h0000]);
    last_rd_addr = 16'h0000;
    prev_hold    = 1'b0;
    prev_br      = 1'b0;
    prev_tgt     = 16'h0000;
  endtask

  // One clock of instance A: drive, sample at #1 after negedge, check, advance model
  task automatic step(input logic rdy, input logic br, input logic [15:0] tgt);
    logic [7:0]  e_op;
    logic [15:0] e_operand;
    int          e_len;
    ready_a = rdy;
    branch_en_a = br;
    branch_target_a = tgt;
    #1;
    chk("valid", instr_valid_a, (cyc >= exp_valid_at));
    if (cyc == 0 && !br) begin
      chk("first_rd", mem_rd_a, 1'b1);
      chk("first_addr", mem_addr_a, model_pc);
    end
    if (prev_br && !br) begin
      chk("br_rd", mem_rd_a, 1'b1);
      chk("br_addr", mem_addr_a, prev_tgt);
    end
    if (prev_hold) begin
      chk("stable_op", op_code_a, prev_op);
      chk("stable_operand", operand_a, prev_operand);
      chk("stable_len", operand_len_a, prev_len);
      chk("stable_pc", instr_pc_a, prev_pc);
    end
    if (!mem_rd_a) chk("addr_hold", mem_addr_a, last_rd_addr);
    if (instr_valid_a && rdy) begin
      e_op = mem_a[model_pc];
      e_len = ref_len(e_op);
      if (e_len == 0) e_operand = 16'h0000;
      else if (e_len == 1) e_operand = {8'h00, mem_a[model_pc + 16'd1]};
      else e_operand = {mem_a[model_pc + 16'd1], mem_a[model_pc + 16'd2]};
      chk("op", op_code_a, e_op);
      chk("operand", operand_a, e_operand);
      chk("len", operand_len_a, e_len[1:0]);
      chk("ipc", instr_pc_a, model_pc);
      model_pc = model_pc + 16'(1 + e_len);
      if (!br) begin
        chk("fused_rd", mem_rd_a, 1'b1);
        chk("fused_addr", mem_addr_a, model_pc);
        exp_valid_at = cyc + 2 + ref_len(mem_a[model_pc]);
      end
    end else if (instr_valid_a && !br) begin
      chk("hold_rd", mem_rd_a, 1'b0);
    end
    if (br) begin
      model_pc = tgt;
      exp_valid_at = cyc + 3 + ref_len(mem_a[tgt]);
    end
    if (mem_rd_a) last_rd_addr = mem_addr_a;
    prev_hold    = instr_valid_a && !rdy && !br;
    prev_op      = op_code_a;
    prev_operand = operand_a;
    prev_len     = operand_len_a;
    prev_pc      = instr_pc_a;
    prev_br      = br;
    prev_tgt     = tgt;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rst_nb = 1'b0;
    ready_a = 1'b0;
    branch_en_a = 1'b0;
    branch_target_a = 16'h0000;
    ready_b = 1'b1;
    branch_en_b = 1'b0;
    branch_target_b = 4'h0;
    for (int i = 0; i < 16; i++) mem_b[i] = 8'h00;
    @(negedge clk);

    // Zero-operand stream, one instruction every 2 cycles
    clear_mem();
    mem_a[0] = 8'h02; mem_a[1] = 8'h03; mem_a[2] = 8'h04; mem_a[3] = 8'h60;
    do_reset();
    for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 16'h0000);

    // 1- and 2-operand instructions; stall on the 0x11 for 5 cycles
    clear_mem();
    mem_a[0] = 8'h10; mem_a[1] = 8'hFF; mem_a[2] = 8'h11; mem_a[3] = 8'h12; mem_a[4] = 8'h34;
    do_reset();
    for (int c = 0; c < 20; c++) step(!(c >= 7 && c <= 11), 1'b0, 16'h0000);

    // Redirect during L_ARG1 of a 3-byte instruction
    clear_mem();
    mem_a[0] = 8'hA7; mem_a[1] = 8'h01; mem_a[2] = 8'h02;
    mem_a[16'h40] = 8'h10; mem_a[16'h41] = 8'h55;
    do_reset();
    for (int c = 0; c < 14; c++) step(1'b1, (c == 2), 16'h0040);

    // Random program, random back-pressure and redirects
    for (int i = 0; i < 65536; i++) mem_a[i] = 8'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0), 16'($urandom));
    end

    // Reset asserted mid L_ARG2, then restart
    clear_mem();
    mem_a[0] = 8'hA7; mem_a[1] = 8'h12; mem_a[2] = 8'h34;
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 16'h0000);
    do_reset();
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 16'h0000);

    // Narrow PC wraps from 15 to 0
    mem_b[15] = 8'h10;
    mem_b[0]  = 8'h7F;
    #1;
    chk("b_rst_rd", mem_rd_b, 1'b0);
    chk("b_rst_addr", mem_addr_b, 4'h0);
    @(negedge clk);
    rst_nb = 1'b1;
    #1;
    chk("b_f_rd", mem_rd_b, 1'b1);
    chk("b_f_addr", mem_addr_b, 4'hF);
    @(negedge clk); #1;
    chk("b_wrap_addr", mem_addr_b, 4'h0);
    chk("b_wrap_rd", mem_rd_b, 1'b1);
    @(negedge clk); #1;
    chk("b_arg_rd", mem_rd_b, 1'b0);
    chk("b_arg_valid", instr_valid_b, 1'b0);
    @(negedge clk); #1;
    chk("b_valid", instr_valid_b, 1'b1);
    chk("b_op", op_code_b, 8'h10);
    chk("b_operand", operand_b, 16'h007F);
    chk("b_len", operand_len_b, 2'd1);
    chk("b_ipc", instr_pc_b, 4'hF);
    chk("b_next_rd", mem_rd_b, 1'b1);
    chk("b_next_addr", mem_addr_b, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
